// File: rtl/lt24_req_if.sv
// Request side of the LT24 write sequencer: CPU register port and pixel stream port.
// The master drives requests; the sequencer (slave) returns the ready strobes.
interface lt24_req_if #(
  parameter int DATA_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dc;
  logic [DATA_W-1:0] cmd_data;
  logic              pix_valid;
  logic              pix_ready;
  logic [DATA_W-1:0] pix_data;
  logic              pix_en;

  modport master (
    output cmd_valid, cmd_dc, cmd_data, pix_valid, pix_data, pix_en,
    input  cmd_ready, pix_ready
  );

  modport slave (
    input  cmd_valid, cmd_dc, cmd_data, pix_valid, pix_data, pix_en,
    output cmd_ready, pix_ready
  );
endinterface

// File: rtl/lt24_write_sequencer.sv
// LT24 8080-style write sequencer: LCD reset/power-up sequence, then timed word writes
// arbitrated between CPU commands and pixel stream. Define LT24_SEQ_STATS_EN for word_count.
module lt24_write_sequencer #(
  parameter int DATA_W       = 16,
  parameter int WR_LOW_CYC   = 2,
  parameter int WR_HIGH_CYC  = 2,
  parameter int RST_LOW_CYC  = 500,
  parameter int RST_WAIT_CYC = 6000,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  lt24_req_if.slave         bus,
  input  logic              hw_reset_req,
  output logic              busy,
  output logic              init_done,
  output logic [DATA_W-1:0] lcd_data_out,
  output logic              lcd_command_data,
  output logic              lcd_write,
  output logic              lcd_chipselect,
  output logic              lcd_reset_x
`ifdef LT24_SEQ_STATS_EN
  ,
  output logic [31:0]       word_count
`endif
);

  localparam logic [2:0] ST_RST_LOW  = 3'd0;
  localparam logic [2:0] ST_RST_WAIT = 3'd1;
  localparam logic [2:0] ST_IDLE     = 3'd2;
  localparam logic [2:0] ST_WR_LOW   = 3'd3;
  localparam logic [2:0] ST_WR_HIGH  = 3'd4;

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_init_done;
  logic [DATA_W-1:0] r_data;
  logic              r_dc;
  logic              r_wr;
  logic              r_cs;
  logic              r_reset_x;

  logic              w_last_rst_low;
  logic              w_last_rst_wait;
  logic              w_last_wr_low;
  logic              w_last_wr_high;
  logic              w_accept;
  logic              w_cmd_xfer;
  logic              w_pix_xfer;
  logic              w_xfer;
  logic [DATA_W-1:0] w_word_data;
  logic              w_word_dc;

  assign w_last_rst_low  = (r_cnt == CNT_W'(RST_LOW_CYC - 1));
  assign w_last_rst_wait = (r_cnt == CNT_W'(RST_WAIT_CYC - 1));
  assign w_last_wr_low   = (r_cnt == CNT_W'(WR_LOW_CYC - 1));
  assign w_last_wr_high  = (r_cnt == CNT_W'(WR_HIGH_CYC - 1));

  // A new word can be taken when idle, or in the final high cycle so writes chain back-to-back.
  assign w_accept = r_init_done &
                    ((r_state == ST_IDLE) || ((r_state == ST_WR_HIGH) && w_last_wr_high));

  assign bus.cmd_ready = w_accept;
  assign bus.pix_ready = w_accept & bus.pix_en & ~bus.cmd_valid;

  assign w_cmd_xfer  = bus.cmd_valid & bus.cmd_ready;
  assign w_pix_xfer  = bus.pix_valid & bus.pix_ready;
  assign w_xfer      = w_cmd_xfer | w_pix_xfer;
  assign w_word_data = w_cmd_xfer ? bus.cmd_data : bus.pix_data;
  assign w_word_dc   = w_cmd_xfer ? bus.cmd_dc : 1'b1;

  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_RST_LOW;
      r_cnt       <= '0;
      r_busy      <= 1'b1;
      r_init_done <= 1'b0;
      r_data      <= '0;
      r_dc        <= 1'b1;
      r_wr        <= 1'b1;
      r_cs        <= 1'b1;
      r_reset_x   <= 1'b0;
    end else if (hw_reset_req) begin
      // Any in-flight word is abandoned; the bus is released and the panel reset restarts.
      r_state     <= ST_RST_LOW;
      r_cnt       <= '0;
      r_busy      <= 1'b1;
      r_init_done <= 1'b0;
      r_wr        <= 1'b1;
      r_cs        <= 1'b1;
      r_reset_x   <= 1'b0;
    end else begin
      case (r_state)
        ST_RST_LOW: begin
          if (w_last_rst_low) begin
            r_state   <= ST_RST_WAIT;
            r_cnt     <= '0;
            r_reset_x <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RST_WAIT: begin
          if (w_last_rst_wait) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_init_done <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_IDLE: begin
          if (w_xfer) begin
            r_state <= ST_WR_LOW;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_cs    <= 1'b0;
            r_wr    <= 1'b0;
            r_data  <= w_word_data;
            r_dc    <= w_word_dc;
          end
        end
        ST_WR_LOW: begin
          if (w_last_wr_low) begin
            r_state <= ST_WR_HIGH;
            r_cnt   <= '0;
            r_wr    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_WR_HIGH: begin
          if (!w_last_wr_high) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else if (w_xfer) begin
            r_state <= ST_WR_LOW;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_data  <= w_word_data;
            r_dc    <= w_word_dc;
          end else begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_cs    <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_RST_LOW;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign busy             = r_busy;
  assign init_done        = r_init_done;
  assign lcd_data_out     = r_data;
  assign lcd_command_data = r_dc;
  assign lcd_write        = r_wr;
  assign lcd_chipselect   = r_cs;
  assign lcd_reset_x      = r_reset_x;

`ifdef LT24_SEQ_STATS_EN
  logic [31:0] r_word_count;

  // Only reset_n clears the count; hw_reset_req leaves it running.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_word_count <= '0;
    end else if (w_xfer) begin
      r_word_count <= r_word_count + 32'd1;
    end
  end

  assign word_count = r_word_count;
`endif

endmodule
